flag_unit: RTL
==============

FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands and result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 SrcA  input  WIDTH  ALU operand A.
REQ-005 SrcB  input  WIDTH  ALU operand B.
REQ-006 ALUControl  input  2  op: 00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-007 FlagW  input  2  bit1 = write N,Z; bit0 = write C,V.
REQ-008 FlagEn  input  1  write window (execute state of control FSM); no flag update when low.
REQ-009 CondEx  input  1  condition-pass for the current instruction; gates all flag writes.
REQ-010 ALUResult  output  WIDTH  combinational ALU result.
REQ-011 Flags  output  4  registered NZCV: bit3 N, bit2 Z, bit1 C, bit0 V.
REQ-012 FlagsNext  output  4  combinational value Flags takes at next edge (forwarding path).
REQ-013 CondExD  output  1  CondEx registered one cycle, for writeback-stage gating.

Function
REQ-014 ADD result = SrcA+SrcB mod 2^WIDTH; SUB result = SrcA+~SrcB+1 mod 2^WIDTH; AND/ORR bitwise.
REQ-015 N = result[WIDTH-1]; Z = 1 iff result == 0, for all ops.
REQ-016 C = carry-out of the WIDTH-bit adder for ADD/SUB (SUB: C=1 means no borrow); C = 0 for AND/ORR.
REQ-017 V = 1 iff ADD/SUB operands (after SrcB inversion for SUB) share sign and result sign differs; V = 0 for AND/ORR.
REQ-018 Write enable NZ = FlagW[1] & FlagEn & CondEx; write enable CV = FlagW[0] & FlagEn & CondEx.
REQ-019 Each flag pair updates independently; a disabled pair holds its previous value.
REQ-020 Latency: flags computed in cycle t visible on Flags in cycle t+1; FlagsNext equals that value in cycle t.
REQ-021 FlagsNext = Flags when both write enables are low.
REQ-022 CondExD <= CondEx every cycle regardless of FlagEn.
REQ-023 Back-to-back writes: each cycle's enabled write overrides; no write coalescing or stall.
REQ-024 Unused ALUControl combinations: none; all four encodings defined.

Reset
REQ-025 On reset high at edge: Flags <= 4'b0000, CondExD <= 0; reset overrides any simultaneous write.
REQ-026 While reset high, FlagsNext = 4'b0000; ALUResult remains combinational.
REQ-027 Reset mid-operation discards the in-flight flag write; first post-reset write behaves per REQ-018.

Structure
REQ-028 Shared package flag_pkg holds ALUControl encodings, FlagW bit indices and NZCV bit positions.
REQ-029 One sub-module alu (WIDTH parameter) produces result and raw NZCV; flag_unit holds registers and gating.
REQ-030 Flag bit order SHALL match the NZCV order consumed by the existing condition checker.

Verification
REQ-031 ADD 0x7FFFFFFF+0x00000001, FlagW=11, FlagEn=1, CondEx=1 -> next cycle Flags=1001 (N,V), ALUResult=0x80000000.
REQ-032 SUB 5-5, FlagW=11 -> Flags=0110 (Z,C); then SUB 3-5 -> Flags=1000 (N, borrow).
REQ-033 Flags=0110, AND 0xF0&0x0F with FlagW=10 -> Flags=0110 (Z set, C held at 1, V held 0).
REQ-034 CondEx=0 or FlagEn=0 with FlagW=11 on ADD 0xFFFFFFFF+1 -> Flags unchanged, FlagsNext=Flags; CondExD follows CondEx by one cycle.
REQ-035 Reset asserted same cycle as enabled write producing 1111-class flags -> Flags=0000, CondExD=0 next cycle.

Source files
------------

// File: rtl/flag_pkg.sv
// flag_pkg: ALU op encodings, FlagW bit indices and NZCV bit positions shared by the flag unit
package flag_pkg;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;
  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;
  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;
endpackage

// File: rtl/flag_unit_alu.sv
// alu: combinational ADD/SUB/AND/ORR with raw NZCV (a, b operands; op select; y result; nzcv raw flags)
module alu
  import flag_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       nzcv
);
  logic             sub;
  logic             arith;
  logic [WIDTH-1:0] bb;
  logic [WIDTH:0]   sum;
  // SUB is a + ~b + 1, so carry out means no borrow and overflow uses the inverted operand sign
  always_comb begin
    sub = op == ALU_SUB;
    arith = op == ALU_ADD || sub;
    bb = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
    y = op == ALU_AND ? a & b : op == ALU_ORR ? a | b : sum[WIDTH-1:0];
    nzcv[F_N] = y[WIDTH-1];
    nzcv[F_Z] = y == '0;
    nzcv[F_C] = arith & sum[WIDTH];
    nzcv[F_V] = arith & (a[WIDTH-1] == bb[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
  end
endmodule

// File: rtl/flag_unit.sv
// flag_unit: ALU plus gated NZCV flag register with forwarding and registered condition pass
// clk/reset: clock, sync active-high reset; SrcA/SrcB/ALUControl: ALU inputs; FlagW/FlagEn/CondEx: write gating
// ALUResult: comb result; Flags: registered NZCV; FlagsNext: next Flags value; CondExD: CondEx delayed one cycle
module flag_unit
  import flag_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [1:0]       ALUControl,
  input  logic [1:0]       FlagW,
  input  logic             FlagEn,
  input  logic             CondEx,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       Flags,
  output logic [3:0]       FlagsNext,
  output logic             CondExD
);
  logic [3:0] nzcv;
  logic       we_nz;
  logic       we_cv;
  alu #(.WIDTH(WIDTH)) u_alu (
    .a   (SrcA),
    .b   (SrcB),
    .op  (ALUControl),
    .y   (ALUResult),
    .nzcv(nzcv)
  );
  always_comb begin
    we_nz = FlagW[FW_NZ] & FlagEn & CondEx;
    we_cv = FlagW[FW_CV] & FlagEn & CondEx;
    FlagsNext = reset ? 4'b0000 : {we_nz ? nzcv[F_N:F_Z] : Flags[F_N:F_Z],
                                   we_cv ? nzcv[F_C:F_V] : Flags[F_C:F_V]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= 4'b0000;
      CondExD <= 1'b0;
    end else begin
      Flags <= FlagsNext;
      CondExD <= CondEx;
    end
  end
endmodule
